// File: rtl/uga_uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver: captures a byte on each
// rising edge of rx_data_ready, back-pressures the receiver, and flags drops.
module uga_uart_rx_fifo #(
   parameter int DEPTH       = 16,
   parameter int AFULL_LEVEL = DEPTH - 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               rx_data,
   input  logic                     rx_data_ready,
   output logic                     rx_en,
   output logic [7:0]               m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     almost_full,
   output logic                     overflow,
   input  logic                     ovf_clr,
   input  logic                     flush
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LEVEL);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          rdy_q;
   logic          rise;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;

   // rdy_q resets high so the receiver's idle-high level never looks like a new byte.
   assign rise = rx_data_ready & ~rdy_q;
   assign full = (level == DEPTH_L);
   assign pop  = m_valid & m_ready & ~flush;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push = rise & (~full | pop) & ~flush;
   assign drop = rise & full & ~pop & ~flush;

   assign m_valid     = (level != '0);
   assign m_data      = m_valid ? mem[rd_ptr] : 8'h00;
   assign almost_full = (level >= AFULL_L);
   assign rx_en       = ~almost_full;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdy_q    <= 1'b1;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         rdy_q <= rx_data_ready;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
         end
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

endmodule
